// File: rtl/irq_controller_pkg.sv
// -----------------------------------------------------------------------------
// irq_controller_pkg
// Shared definitions for the interrupt controller: register offsets on the
// CPU store bus (word index taken from addr[3:2]) and the FSM state encoding.
// The encoding values are visible to software through STATUS[9:8].
// -----------------------------------------------------------------------------
package irq_controller_pkg;

  localparam logic [1:0] REG_MASK = 2'd0;
  localparam logic [1:0] REG_PEND = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_SVC  = 2'b10
  } state_e;

endpackage

// File: rtl/irq_controller_if.sv
// -----------------------------------------------------------------------------
// irq_controller_if
// Bundles the CPU store bus, the device interrupt lines and the CP0
// request/acknowledge handshake of the interrupt controller.
//   we, addr, din  : register write strobe, word select, write data
//   dout           : combinational read data for the selected register
//   irq_in         : device interrupt lines, bit 0 highest priority
//   int_ack        : one-cycle pulse from CP0 when it takes the exception
//   int_req, int_id: request to CP0 and id of the requested/in-service source
// master: the CPU/peripheral side; slave: the controller.
// -----------------------------------------------------------------------------
interface irq_controller_if #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
);

  logic              we;
  logic [1:0]        addr;
  logic [31:0]       din;
  logic [31:0]       dout;
  logic [N_SRC-1:0]  irq_in;
  logic              int_ack;
  logic              int_req;
  logic [ID_W-1:0]   int_id;

  modport master (
    output we, addr, din, irq_in, int_ack,
    input  dout, int_req, int_id
  );

  modport slave (
    input  we, addr, din, irq_in, int_ack,
    output dout, int_req, int_id
  );

endinterface

// File: rtl/irq_controller_prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
// Combinational fixed-priority encoder: the lowest set index of req_i wins.
//   req_i   : N_SRC request vector (masked pending bits)
//   id_o    : index of the winning request (0 when none)
//   valid_o : at least one request is set
// -----------------------------------------------------------------------------
module prio_enc #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_SRC-1:0] req_i,
  output logic [ID_W-1:0]  id_o,
  output logic             valid_o
);

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    id_o    = '0;
    valid_o = 1'b0;
    // Scan from the top down so the last hit, i.e. the lowest index, sticks.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        id_o    = ID_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Programmable interrupt controller between memory-mapped peripherals and the
// CPU's CP0 interrupt input. Device lines are captured into PENDING, gated by
// MASK, and one winner (lowest index) is requested from CP0. After int_ack the
// source stays in service until software writes EOI.
//
// Ports:
//   clk : system clock, all state on posedge
//   rst : synchronous, active-high reset
//   bus : irq_controller_if.slave (store bus, irq lines, CP0 handshake)
//
// Registers (addr[3:2]):
//   0 MASK    RW  bits [N_SRC-1:0], 1 = enabled
//   1 PENDING R   write-1-to-clear
//   2 STATUS  R   {state at [9:8], int_id at [ID_W-1:0]}
//   3 EOI     W   any write ends service; reads 0
//
// Build option: define IRQ_LEVEL_EN for level-sensitive capture (PENDING bit
// set every cycle its line is high). Default is rising-edge capture.
// -----------------------------------------------------------------------------
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  irq_controller_if.slave    bus
);

  state_e            state_q, state_d;
  logic [N_SRC-1:0]  mask_q, mask_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic              int_req_q, int_req_d;
  logic [ID_W-1:0]   int_id_q, int_id_d;

  logic [N_SRC-1:0]  set_vec;
  logic [N_SRC-1:0]  w1c_vec;
  logic [ID_W-1:0]   enc_id;
  logic              enc_valid;
  logic              ack_take;
  logic              wr_mask, wr_pend, wr_eoi;
  logic [31:0]       rdata;

  assign wr_mask = bus.we && (bus.addr == REG_MASK);
  assign wr_pend = bus.we && (bus.addr == REG_PEND);
  assign wr_eoi  = bus.we && (bus.addr == REG_EOI);

`ifdef IRQ_LEVEL_EN
  // Level capture: a held line re-sets its bit every cycle, so W1C only
  // sticks once the device has dropped the line.
  assign set_vec = bus.irq_in;
`else
  logic [N_SRC-1:0] irq_prev_q;

  // Edge capture against the registered line; irq_prev_q resets to 0 so a
  // line already high at reset release counts as an edge.
  assign set_vec = bus.irq_in & ~irq_prev_q;

  always_ff @(posedge clk) begin
    if (rst) irq_prev_q <= '0;
    else     irq_prev_q <= bus.irq_in;
  end
`endif

  prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req_i   (pend_q & mask_q),
    .id_o    (enc_id),
    .valid_o (enc_valid)
  );

  // Arbitration / handshake FSM. int_req is registered from the REQ state,
  // so it rises one cycle after the IDLE decision.
  always_comb begin
    state_d   = state_q;
    int_req_d = 1'b0;
    int_id_d  = int_id_q;
    ack_take  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d  = ST_REQ;
          int_id_d = enc_id;
        end
      end
      ST_REQ: begin
        // The latched id is kept; a later higher-priority source waits.
        if (bus.int_ack) begin
          ack_take = 1'b1;
          state_d  = ST_SVC;
        end else if (!pend_q[int_id_q] || !mask_q[int_id_q]) begin
          state_d = ST_IDLE;
        end else begin
          int_req_d = 1'b1;
        end
      end
      ST_SVC: begin
        if (wr_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register file next-state. A new edge beats a same-cycle W1C; the ack
  // clear of the taken source beats everything on that bit.
  always_comb begin
    mask_d  = wr_mask ? bus.din[N_SRC-1:0] : mask_q;
    w1c_vec = wr_pend ? bus.din[N_SRC-1:0] : '0;
    pend_d  = (pend_q & ~w1c_vec) | set_vec;
    if (ack_take) pend_d[int_id_q] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      pend_q    <= '0;
      int_req_q <= 1'b0;
      int_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      int_req_q <= int_req_d;
      int_id_q  <= int_id_d;
    end
  end

  // Read mux: purely combinational, no read side effects.
  always_comb begin
    rdata = '0;
    case (bus.addr)
      REG_MASK: rdata[N_SRC-1:0] = mask_q;
      REG_PEND: rdata[N_SRC-1:0] = pend_q;
      REG_STAT: begin
        rdata[9:8]      = state_q;
        rdata[ID_W-1:0] = int_id_q;
      end
      default: rdata = '0;
    endcase
  end

  assign bus.dout    = rdata;
  assign bus.int_req = int_req_q;
  assign bus.int_id  = int_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
// Self-checking bench for irq_controller (N_SRC=4, ID_W=2). A table of
// one-cycle vectors drives the bus and irq lines; the expected int_req,
// int_id and read data of each row go through a scoreboard queue and are
// compared one cycle later. Hand-written sequences cover latency, reset in
// service, reset-release edge detection and (IRQ_LEVEL_EN) level capture.
// -----------------------------------------------------------------------------
module tb_irq_controller;

  localparam int N_SRC = 4;
  localparam int ID_W  = 2;

  localparam logic [1:0] A_MASK = 2'd0;
  localparam logic [1:0] A_PEND = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_EOI  = 2'd3;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  wa;
    logic [31:0] din;
    logic [3:0]  irq;
    logic        ack;
    logic [1:0]  ra;
    logic        exp_req;
    logic [1:0]  exp_id;
    logic [31:0] exp_dout;
  } vec_t;

  typedef struct {
    string       name;
    logic        req;
    logic [1:0]  id;
    logic [31:0] dout;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  vec_t vecs[$];
  exp_t sb[$];

  irq_controller_if #(.N_SRC(N_SRC), .ID_W(ID_W)) bus ();

  irq_controller #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic we, input logic [1:0] wa,
                     input logic [31:0] din, input logic [3:0] irq, input logic ack,
                     input logic [1:0] ra, input logic exp_req, input logic [1:0] exp_id,
                     input logic [31:0] exp_dout);
    vec_t v;
    v.name = name; v.we = we; v.wa = wa; v.din = din; v.irq = irq; v.ack = ack;
    v.ra = ra; v.exp_req = exp_req; v.exp_id = exp_id; v.exp_dout = exp_dout;
    vecs.push_back(v);
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(name, bus.dout, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.we   = 1'b1;
    bus.addr = a;
    bus.din  = d;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
    bus.din  = '0;
  endtask

  initial begin
    exp_t e;
    int   lat;
    checks   = 0;
    failures = 0;

    //   name        we wa      din    irq     ack ra      req id  dout
    add("a_mask",    1, A_MASK, 32'h3, 4'b0000, 0, A_MASK, 0, 0, 32'h003);
    add("a_edge1",   0, A_MASK, 32'h0, 4'b0010, 0, A_PEND, 0, 0, 32'h002);
    add("a_decide",  0, A_MASK, 32'h0, 4'b0000, 0, A_STAT, 0, 1, 32'h101);
    add("a_req",     0, A_MASK, 32'h0, 4'b0000, 0, A_STAT, 1, 1, 32'h101);
    add("a_ack",     0, A_MASK, 32'h0, 4'b0000, 1, A_PEND, 0, 1, 32'h000);
    add("a_svc",     0, A_MASK, 32'h0, 4'b0000, 0, A_STAT, 0, 1, 32'h201);
    add("a_eoi",     1, A_EOI,  32'h0, 4'b0000, 0, A_STAT, 0, 1, 32'h001);
    add("b_both",    1, A_MASK, 32'hF, 4'b1001, 0, A_PEND, 0, 1, 32'h009);
    add("b_dec0",    0, A_MASK, 32'h0, 4'b0000, 0, A_STAT, 0, 0, 32'h100);
    add("b_req0",    0, A_MASK, 32'h0, 4'b0000, 0, A_STAT, 1, 0, 32'h100);
    add("b_ack0",    0, A_MASK, 32'h0, 4'b0000, 1, A_PEND, 0, 0, 32'h008);
    add("b_eoi0",    1, A_EOI,  32'h0, 4'b0000, 0, A_STAT, 0, 0, 32'h000);
    add("b_dec3",    0, A_MASK, 32'h0, 4'b0000, 0, A_STAT, 0, 3, 32'h103);
    add("b_req3",    0, A_MASK, 32'h0, 4'b0000, 0, A_STAT, 1, 3, 32'h103);
    add("b_ack3",    0, A_MASK, 32'h0, 4'b0000, 1, A_PEND, 0, 3, 32'h000);
    add("b_eoi3",    1, A_EOI,  32'h0, 4'b0000, 0, A_STAT, 0, 3, 32'h003);
    add("c_mask0",   1, A_MASK, 32'h0, 4'b0000, 0, A_MASK, 0, 3, 32'h000);
    add("c_edge2",   0, A_MASK, 32'h0, 4'b0100, 0, A_PEND, 0, 3, 32'h004);
    add("c_masked",  0, A_MASK, 32'h0, 4'b0000, 0, A_STAT, 0, 3, 32'h003);
    add("c_mask4",   1, A_MASK, 32'h4, 4'b0000, 0, A_MASK, 0, 3, 32'h004);
    add("c_dec2",    0, A_MASK, 32'h0, 4'b0000, 0, A_STAT, 0, 2, 32'h102);
    add("c_req2",    0, A_MASK, 32'h0, 4'b0000, 0, A_STAT, 1, 2, 32'h102);
    add("d_unmask",  1, A_MASK, 32'h0, 4'b0000, 0, A_MASK, 1, 2, 32'h000);
    add("d_cancel",  0, A_MASK, 32'h0, 4'b0000, 0, A_STAT, 0, 2, 32'h002);
    add("d_pendkeep",0, A_MASK, 32'h0, 4'b0000, 0, A_PEND, 0, 2, 32'h004);
`ifndef IRQ_LEVEL_EN
    add("e_w1c",     1, A_PEND, 32'h4, 4'b0000, 0, A_PEND, 0, 2, 32'h000);
    add("e_edge1",   0, A_MASK, 32'h0, 4'b0010, 0, A_PEND, 0, 2, 32'h002);
    add("e_low",     0, A_MASK, 32'h0, 4'b0000, 0, A_PEND, 0, 2, 32'h002);
    add("e_setwins", 1, A_PEND, 32'h2, 4'b0010, 0, A_PEND, 0, 2, 32'h002);
    add("e_w1c_ok",  1, A_PEND, 32'h2, 4'b0010, 0, A_PEND, 0, 2, 32'h000);
    add("e_idle",    0, A_MASK, 32'h0, 4'b0000, 0, A_PEND, 0, 2, 32'h000);
`else
    add("e_w1c",     1, A_PEND, 32'h4, 4'b0000, 0, A_PEND, 0, 2, 32'h000);
`endif

    // Reset state.
    rst         = 1'b1;
    bus.we      = 1'b0;
    bus.addr    = A_MASK;
    bus.din     = '0;
    bus.irq_in  = '0;
    bus.int_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(bus.int_req), 32'h0);
    check("rst_id",  32'(bus.int_id),  32'h0);
    read_check("rst_mask", A_MASK, 32'h0);
    read_check("rst_pend", A_PEND, 32'h0);
    read_check("rst_stat", A_STAT, 32'h0);
    read_check("rst_eoi",  A_EOI,  32'h0);
    rst = 1'b0;

    // Table-driven vectors through the scoreboard.
    foreach (vecs[i]) begin
      bus.we      = vecs[i].we;
      bus.addr    = vecs[i].wa;
      bus.din     = vecs[i].din;
      bus.irq_in  = vecs[i].irq;
      bus.int_ack = vecs[i].ack;
      e.name = vecs[i].name;
      e.req  = vecs[i].exp_req;
      e.id   = vecs[i].exp_id;
      e.dout = vecs[i].exp_dout;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.we      = 1'b0;
      bus.int_ack = 1'b0;
      bus.din     = '0;
      bus.addr    = vecs[i].ra;
      #1;
      e = sb.pop_front();
      check({e.name, "_req"},  32'(bus.int_req), 32'(e.req));
      check({e.name, "_id"},   32'(bus.int_id),  32'(e.id));
      check({e.name, "_dout"}, bus.dout,         e.dout);
    end

    // Latency from an irq edge to int_req, then reset during SERVICE.
    bus.irq_in = '0;
    bus_write(A_MASK, 32'hF);
    bus_write(A_PEND, 32'hF);
    bus.irq_in = 4'b0010;
    @(posedge clk);
    #1;
    bus.irq_in = '0;
    lat = 0;
    while (!bus.int_req && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("f_latency", 32'(lat), 32'd2);
    check("f_id",      32'(bus.int_id), 32'h1);
    bus.int_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.int_ack = 1'b0;
    read_check("f_svc_stat", A_STAT, 32'h201);
    bus.irq_in = 4'b1000;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("f_rst_req", 32'(bus.int_req), 32'h0);
    check("f_rst_id",  32'(bus.int_id),  32'h0);
    read_check("f_rst_mask", A_MASK, 32'h0);
    read_check("f_rst_pend", A_PEND, 32'h0);
    read_check("f_rst_stat", A_STAT, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    read_check("f_release_edge", A_PEND, 32'h8);
    check("f_release_req", 32'(bus.int_req), 32'h0);
    bus.irq_in = '0;

`ifdef IRQ_LEVEL_EN
    // Held line keeps its pending bit despite W1C.
    bus.irq_in = 4'b0001;
    @(posedge clk);
    #1;
    bus_write(A_PEND, 32'h1);
    read_check("g_level_hold", A_PEND, 32'h9);
    bus.irq_in = '0;
    bus_write(A_PEND, 32'h1);
    read_check("g_level_clear", A_PEND, 32'h8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Programmable interrupt controller between the memory-mapped peripherals (timers and other devices) and the CPU's CP0 interrupt input.
- Captures device interrupt lines into a pending register and applies a mask.
- Picks one winner by fixed priority, presents it to the CPU with a request/acknowledge handshake, and holds it in service until software writes end-of-interrupt (EOI).
- Sits on the same CPU store bus as the timers: word-addressed by addr[3:2], with we and din.

Parameters:
- N_SRC, 4, number of interrupt source lines (1..16).
- ID_W, 2, width of the interrupt id; must equal clog2(N_SRC), minimum 1.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  register write strobe from CPU bus (already address-decoded for this block).
- addr  in  2 ([3:2])  register select.
- din  in  32  write data.
- dout  out  32  read data for the selected register.
- irq_in  in  N_SRC  device interrupt lines; bit 0 is highest priority.
- int_ack  in  1  one-cycle pulse from CP0 when it takes the interrupt exception.
- int_req  out  1  interrupt request to CP0.
- int_id  out  ID_W  id of the requested or in-service source.

Behaviour:
- Registers (addr):
  - 0 MASK: RW, bits [N_SRC-1:0]; 1 = enabled. Upper bits read as 0.
  - 1 PENDING: R; a write clears every bit set in din (write-1-to-clear).
  - 2 STATUS: R; {state[1:0] at bits 9:8, int_id at bits ID_W-1:0}, other bits 0.
  - 3 EOI: W; any write ends service. Reads return 0.
- dout is combinational from addr and current register values; there is no read side effect.
- Reset values: MASK=0, PENDING=0, irq_prev=0, state=IDLE, int_req=0, int_id=0, dout reflects these.
- Capture (default): PENDING[i] is set on a rising edge of irq_in[i], detected against the registered irq_prev[i].
  - A line already high at reset release is seen as an edge on the first cycle after rst drops.
  - If a set and a W1C hit the same bit in the same cycle, set wins.
- FSM (state encoding 00/01/10):
  - IDLE:
    - If (PENDING & MASK) != 0, latch the winner (lowest set index) into int_id and go to REQ.
    - int_req=0 in IDLE.
  - REQ:
    - int_req=1, registered, so it asserts the cycle after the IDLE decision.
    - If int_ack: clear PENDING[int_id] (overrides a same-cycle set on that bit), drop int_req, go to SERVICE.
    - Otherwise, if PENDING[int_id] or MASK[int_id] is now 0 (software cleared or masked it): go to IDLE with int_req=0 next cycle.
    - A higher-priority source arriving during REQ does not pre-empt the latched id.
  - SERVICE:
    - int_req=0; int_id holds.
    - New pending bits accumulate but are not requested.
    - A write to EOI returns to IDLE. Re-arbitration happens in IDLE on the following cycle, so there is at least one IDLE cycle between services.
- int_ack outside REQ is ignored. An EOI write outside SERVICE is ignored.
- Assertion of rst in any state returns all state to reset values on the next edge. An in-flight request is dropped with no ack required.
- Minimum latency, irq_in edge to int_req: 3 cycles (edge registered into PENDING, IDLE decision, int_req registered).

Optional Feature:
- IRQ_LEVEL_EN defined:
  - Capture is level-sensitive: PENDING[i] is set every cycle irq_in[i]=1, so W1C has no lasting effect while the line is high.
  - irq_prev is not used.
  - Suits the timer's level intq, which stays high until software reloads the timer.
- Undefined: rising-edge capture as above.

Decomposition:
- Shared package:
  - Register offsets REG_MASK=0, REG_PEND=1, REG_STAT=2, REG_EOI=3.
  - State encoding ST_IDLE=2'b00, ST_REQ=2'b01, ST_SVC=2'b10.
- One sub-module: prio_enc, a combinational lowest-index-wins encoder (N_SRC in, ID_W id out, plus valid) used for the IDLE decision.

Test Plan:
- MASK=4'b0011; pulse irq_in[1] -> int_req=1 three cycles later with int_id=1; int_ack -> int_req=0, PENDING[1]=0, STATUS state=10; EOI write -> state=00.
- MASK=4'b1111; irq_in[3] and irq_in[0] rise in the same cycle -> int_id=0 first. After ack and EOI -> int_req again with int_id=3.
- MASK=0; pulse irq_in[2] -> PENDING=4'b0100 and no int_req; then write MASK=4'b0100 -> int_req with int_id=2.
- In REQ with id=2, write MASK=0 before ack -> int_req=0 next cycle and state=IDLE; PENDING[2] stays 1.
- Same cycle: W1C of PENDING bit 1 and a new edge on irq_in[1] -> PENDING[1]=1.
- rst pulsed during SERVICE -> all registers 0, int_req=0. Under IRQ_LEVEL_EN: hold irq_in[0]=1, write PENDING=1 -> bit reads back 1.
